// File: rtl/axi_lite_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_master_pkg
// Shared types and constants for the AXI4-Lite single-outstanding master.
//   state_t  : controller FSM states
//   OKAY/EXOKAY/SLVERR/DECERR : AXI BRESP/RRESP encodings
//   PROT_NONE : fixed AxPROT value (unprivileged, secure, data)
// ---------------------------------------------------------------------------
package axi_lite_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_NONE = 3'b000;

endpackage

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
// Turns one simple command into one AXI4-Lite transaction and returns the
// slave's response. One transaction is outstanding at a time.
//
// Ports
//   aclk, aresetn         : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_ready is high only in IDLE
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_wstrb  : command payload, latched on acceptance
//   rsp_valid/rsp_ready   : response handshake
//   rsp_write, rsp_rdata,
//   rsp_resp              : response payload (rdata is 0 for writes)
//   m_axi_*               : AXI4-Lite master channels AW, W, B, AR, R
//
// Only DATA_WIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_t                  state_r;
  logic                    cmd_ready_r;
  logic                    rsp_valid_r;
  logic                    rsp_write_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [1:0]              rsp_resp_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic                    awvalid_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH/8-1:0] wstrb_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic [ADDR_WIDTH-1:0]   araddr_r;
  logic                    arvalid_r;
  logic                    rready_r;

  // A channel counts as finished once its valid has already dropped or it
  // handshakes this cycle; this lets AW and W complete in either order.
  logic aw_done_s;
  logic w_done_s;

  assign aw_done_s = !awvalid_r || m_axi_awready;
  assign w_done_s  = !wvalid_r  || m_axi_wready;

  // Transaction FSM; every handshake output is a register driven here.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= OKAY;
      awaddr_r    <= {ADDR_WIDTH{1'b0}};
      awvalid_r   <= 1'b0;
      wdata_r     <= {DATA_WIDTH{1'b0}};
      wstrb_r     <= {(DATA_WIDTH/8){1'b0}};
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      araddr_r    <= {ADDR_WIDTH{1'b0}};
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            rsp_write_r <= cmd_write;
            if (cmd_write) begin
              awaddr_r  <= cmd_addr;
              wdata_r   <= cmd_wdata;
              wstrb_r   <= cmd_wstrb;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= WRITE;
            end else begin
              araddr_r  <= cmd_addr;
              arvalid_r <= 1'b1;
              state_r   <= READ;
            end
          end
        end
        WRITE: begin
          if (awvalid_r && m_axi_awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && m_axi_wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            bready_r <= 1'b1;
            state_r  <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            bready_r    <= 1'b0;
            rsp_resp_r  <= m_axi_bresp;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        READ: begin
          if (m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            rready_r    <= 1'b0;
            rsp_rdata_r <= m_axi_rdata;
            rsp_resp_r  <= m_axi_rresp;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          // cmd_ready rises only on the next cycle, so no command can be
          // taken in the same cycle the response is consumed.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          // Unreachable encodings: drop all handshakes and return to IDLE.
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_write     = rsp_write_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_awprot  = PROT_NONE;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arprot  = PROT_NONE;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master
// Directed bench: drives commands and a scripted AXI4-Lite slave cycle by
// cycle and compares outputs against hand-computed values. Cycle c0 is the
// cycle in which a command is presented with cmd_ready high.
// ---------------------------------------------------------------------------
module tb_axi_lite_master;
  import axi_lite_master_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int checks   = 0;
  int failures = 0;

  int aw_cnt  = 0;
  int w_cnt   = 0;
  int b_cnt   = 0;
  int ar_cnt  = 0;
  int r_cnt   = 0;
  int rsp_cnt = 0;

  int aw0, w0, b0, ar0, r0, rsp0;

  always #5 aclk = ~aclk;

  axi_lite_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  // Handshake counters, sampled on the active edge.
  always @(posedge aclk) begin
    if (aresetn) begin
      if (m_axi_awvalid && m_axi_awready) aw_cnt  <= aw_cnt + 1;
      if (m_axi_wvalid  && m_axi_wready)  w_cnt   <= w_cnt + 1;
      if (m_axi_bvalid  && m_axi_bready)  b_cnt   <= b_cnt + 1;
      if (m_axi_arvalid && m_axi_arready) ar_cnt  <= ar_cnt + 1;
      if (m_axi_rvalid  && m_axi_rready)  r_cnt   <= r_cnt + 1;
      if (rsp_valid     && rsp_ready)     rsp_cnt <= rsp_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic snap;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt; rsp0 = rsp_cnt;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = 4'hF;
  endtask

  initial begin
    aresetn       = 1'b0;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_addr      = 32'h0;
    cmd_wdata     = 32'h0;
    cmd_wstrb     = 4'h0;
    rsp_ready     = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_bvalid  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = 32'h0;
    m_axi_rresp   = 2'b00;
    m_axi_rvalid  = 1'b0;

    // ---- reset state ----
    tick; tick;
    check_eq("rst_awvalid", m_axi_awvalid, 1'b0);
    check_eq("rst_wvalid",  m_axi_wvalid,  1'b0);
    check_eq("rst_arvalid", m_axi_arvalid, 1'b0);
    check_eq("rst_bready",  m_axi_bready,  1'b0);
    check_eq("rst_rready",  m_axi_rready,  1'b0);
    check_eq("rst_rspv",    rsp_valid,     1'b0);
    check_eq("rst_rdata",   rsp_rdata,     32'h0);
    check_eq("rst_resp",    rsp_resp,      2'b00);
    check_eq("rst_awaddr",  m_axi_awaddr,  32'h0);
    check_eq("rst_wdata",   m_axi_wdata,   32'h0);
    check_eq("rst_araddr",  m_axi_araddr,  32'h0);
    check_eq("prot",        {m_axi_awprot, m_axi_arprot}, 6'b000000);
    #3 aresetn = 1'b1;
    tick;
    check_eq("rst_cmdrdy", cmd_ready, 1'b1);

    // ---- write, always-ready slave ----
    snap;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b1;  m_axi_bresp = OKAY;
    send_cmd(1'b1, 32'h44A0_0004, 32'h2);
    tick; // c1
    check_eq("w1_c1_aw",    m_axi_awvalid, 1'b1);
    check_eq("w1_c1_w",     m_axi_wvalid,  1'b1);
    check_eq("w1_awaddr",   m_axi_awaddr,  32'h44A0_0004);
    check_eq("w1_wdata",    m_axi_wdata,   32'h2);
    check_eq("w1_wstrb",    m_axi_wstrb,   4'hF);
    check_eq("w1_c1_bry",   m_axi_bready,  1'b0);
    check_eq("w1_c1_crdy",  cmd_ready,     1'b0);
    cmd_valid = 1'b0;
    tick; // c2
    check_eq("w1_c2_aw",    m_axi_awvalid, 1'b0);
    check_eq("w1_c2_w",     m_axi_wvalid,  1'b0);
    check_eq("w1_c2_bry",   m_axi_bready,  1'b1);
    check_eq("w1_c2_rspv",  rsp_valid,     1'b0);
    tick; // c3
    check_eq("w1_c3_rspv",  rsp_valid,     1'b1);
    check_eq("w1_resp",     rsp_resp,      OKAY);
    check_eq("w1_rspw",     rsp_write,     1'b1);
    check_eq("w1_rdata",    rsp_rdata,     32'h0);
    check_eq("w1_c3_bry",   m_axi_bready,  1'b0);
    rsp_ready = 1'b1;
    tick; // c4
    check_eq("w1_c4_rspv",  rsp_valid,     1'b0);
    check_eq("w1_c4_crdy",  cmd_ready,     1'b1);
    check_eq("w1_beats",    {aw_cnt - aw0, w_cnt - w0, b_cnt - b0, rsp_cnt - rsp0}, {32'd1, 32'd1, 32'd1, 32'd1});
    rsp_ready = 1'b0; m_axi_bvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;

    // ---- write, W first, AW delayed three cycles ----
    snap;
    m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h44A0_0000, 32'h3);
    tick; // c1
    check_eq("w2_c1_aw",    m_axi_awvalid, 1'b1);
    check_eq("w2_c1_w",     m_axi_wvalid,  1'b1);
    cmd_valid = 1'b0;
    tick; // c2
    check_eq("w2_c2_aw",    m_axi_awvalid, 1'b1);
    check_eq("w2_c2_w",     m_axi_wvalid,  1'b0);
    check_eq("w2_c2_bry",   m_axi_bready,  1'b0);
    m_axi_wready = 1'b0;
    tick; // c3
    check_eq("w2_c3_aw",    m_axi_awvalid, 1'b1);
    check_eq("w2_c3_w",     m_axi_wvalid,  1'b0);
    tick; // c4
    check_eq("w2_c4_aw",    m_axi_awvalid, 1'b1);
    check_eq("w2_awaddr",   m_axi_awaddr,  32'h44A0_0000);
    check_eq("w2_wdata",    m_axi_wdata,   32'h3);
    m_axi_awready = 1'b1;
    tick; // c5
    check_eq("w2_c5_aw",    m_axi_awvalid, 1'b0);
    check_eq("w2_c5_bry",   m_axi_bready,  1'b1);
    m_axi_awready = 1'b0; m_axi_bvalid = 1'b1; m_axi_bresp = OKAY;
    tick; // c6
    check_eq("w2_c6_rspv",  rsp_valid,     1'b1);
    check_eq("w2_resp",     {rsp_write, rsp_resp}, {1'b1, OKAY});
    check_eq("w2_c6_bry",   m_axi_bready,  1'b0);
    m_axi_bvalid = 1'b0; rsp_ready = 1'b1;
    tick; // c7
    check_eq("w2_c7_rspv",  rsp_valid,     1'b0);
    check_eq("w2_beats",    {aw_cnt - aw0, w_cnt - w0, b_cnt - b0, rsp_cnt - rsp0}, {32'd1, 32'd1, 32'd1, 32'd1});
    rsp_ready = 1'b0;

    // ---- read, two wait cycles before R ----
    snap;
    check_eq("r1_c0_crdy",  cmd_ready,     1'b1);
    m_axi_arready = 1'b1;
    send_cmd(1'b0, 32'h44A0_0000, 32'h0);
    tick; // c1
    check_eq("r1_c1_ar",    m_axi_arvalid, 1'b1);
    check_eq("r1_araddr",   m_axi_araddr,  32'h44A0_0000);
    check_eq("r1_c1_rrdy",  m_axi_rready,  1'b0);
    check_eq("r1_c1_aw",    m_axi_awvalid, 1'b0);
    cmd_valid = 1'b0;
    tick; // c2
    check_eq("r1_c2_ar",    m_axi_arvalid, 1'b0);
    check_eq("r1_c2_rrdy",  m_axi_rready,  1'b1);
    m_axi_arready = 1'b0;
    tick; // c3
    check_eq("r1_c3_rrdy",  m_axi_rready,  1'b1);
    tick; // c4
    check_eq("r1_c4_rrdy",  m_axi_rready,  1'b1);
    check_eq("r1_c4_rspv",  rsp_valid,     1'b0);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h3; m_axi_rresp = OKAY;
    tick; // c5
    check_eq("r1_c5_rspv",  rsp_valid,     1'b1);
    check_eq("r1_rdata",    rsp_rdata,     32'h3);
    check_eq("r1_rspw",     rsp_write,     1'b0);
    check_eq("r1_resp",     rsp_resp,      OKAY);
    check_eq("r1_c5_rrdy",  m_axi_rready,  1'b0);
    m_axi_rvalid = 1'b0; rsp_ready = 1'b1;
    tick; // c6
    check_eq("r1_beats",    {ar_cnt - ar0, r_cnt - r0, rsp_cnt - rsp0, 1'b0, rsp_valid}, {32'd1, 32'd1, 32'd1, 2'b00});
    rsp_ready = 1'b0;

    // ---- read DECERR; early rvalid must be ignored ----
    snap;
    m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBADB_AD00; m_axi_rresp = DECERR;
    send_cmd(1'b0, 32'hDEAD_0000, 32'h0);
    tick; // c1
    check_eq("r2_c1_ar",    m_axi_arvalid, 1'b1);
    check_eq("r2_c1_rrdy",  m_axi_rready,  1'b0);
    check_eq("r2_araddr",   m_axi_araddr,  32'hDEAD_0000);
    cmd_valid = 1'b0;
    tick; // c2
    check_eq("r2_c2_rrdy",  m_axi_rready,  1'b1);
    m_axi_arready = 1'b0;
    tick; // c3
    check_eq("r2_c3_rspv",  rsp_valid,     1'b1);
    check_eq("r2_resp",     rsp_resp,      2'b11);
    check_eq("r2_rdata",    rsp_rdata,     32'hBADB_AD00);
    m_axi_rvalid = 1'b0; rsp_ready = 1'b1;
    tick; // c4
    check_eq("r2_beats",    {r_cnt - r0, rsp_cnt - rsp0}, {32'd1, 32'd1});
    rsp_ready = 1'b0;

    // ---- SLVERR write, response held off 5 cycles with a pending command ----
    snap;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b1;  m_axi_bresp = SLVERR;
    send_cmd(1'b1, 32'h44A0_0008, 32'h5);
    tick; // c1
    check_eq("h_c1_aw",     m_axi_awvalid, 1'b1);
    send_cmd(1'b0, 32'h0000_0100, 32'h0);
    tick; // c2
    check_eq("h_c2_bry",    m_axi_bready,  1'b1);
    tick; // c3
    m_axi_bvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("h_rspv",    rsp_valid,     1'b1);
      check_eq("h_crdy",    cmd_ready,     1'b0);
      check_eq("h_valids",  {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
      check_eq("h_resp",    {rsp_write, rsp_resp}, {1'b1, SLVERR});
      tick;
    end
    // c8: release the response
    check_eq("h_c8_rspv",   rsp_valid,     1'b1);
    rsp_ready = 1'b1;
    tick; // c9
    check_eq("h_c9_rspv",   rsp_valid,     1'b0);
    check_eq("h_c9_crdy",   cmd_ready,     1'b1);
    check_eq("h_c9_ar",     m_axi_arvalid, 1'b0);
    rsp_ready = 1'b0;
    tick; // c10
    check_eq("h_c10_ar",    m_axi_arvalid, 1'b1);
    check_eq("h_araddr",    m_axi_araddr,  32'h0000_0100);
    check_eq("h_c10_crdy",  cmd_ready,     1'b0);
    cmd_valid = 1'b0; m_axi_arready = 1'b1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    tick; // c11
    check_eq("h_c11_rrdy",  m_axi_rready,  1'b1);
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h55; m_axi_rresp = OKAY;
    tick; // c12
    check_eq("h_rdata",     {rsp_valid, rsp_rdata}, {1'b1, 32'h55});
    m_axi_rvalid = 1'b0; rsp_ready = 1'b1;
    tick; // c13
    check_eq("h_beats",     {aw_cnt - aw0, ar_cnt - ar0, rsp_cnt - rsp0}, {32'd1, 32'd1, 32'd2});
    rsp_ready = 1'b0;

    // ---- reset mid-write ----
    snap;
    send_cmd(1'b1, 32'h44A0_000C, 32'h7);
    tick; // c1
    check_eq("x_c1_aw",     m_axi_awvalid, 1'b1);
    cmd_valid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check_eq("x_aw",        m_axi_awvalid, 1'b0);
    check_eq("x_w",         m_axi_wvalid,  1'b0);
    check_eq("x_rspv",      rsp_valid,     1'b0);
    check_eq("x_addr",      {m_axi_awaddr, m_axi_wdata}, 64'h0);
    tick; tick;
    #3 aresetn = 1'b1;
    tick;
    check_eq("x_crdy",      cmd_ready,     1'b1);
    check_eq("x_aw2",       {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);
    tick; tick;
    check_eq("x_norsp",     {rsp_valid, 31'd0, rsp_cnt - rsp0}, {1'b0, 31'd0, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
